pwm_channel_core: RTL

//  Timing core driven by the pwm_generator AXI4-Lite register bank: consumes period/duty/step/ctrl register values, produces one PWM output for the car's motor/servo driver.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_slew_step.sv | 23 ++
 rtl/pwm_channel_core.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM channel timing core.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_e;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_INV_BIT = 1;

endpackage

// File: rtl/pwm_slew_step.sv
// One slew step: move cur toward target by at most step (step==0 loads target).
module pwm_slew_step #(
  parameter int unsigned CNT_W = 16
) (
  input  logic [CNT_W-1:0] cur,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] step,
  output logic [CNT_W-1:0] next_c
);

  // Differences are taken in the safe direction before any add/sub, so no wrap.
  always_comb begin
    next_c = target;
    if (step != '0) begin
      if (target > cur) begin
        if ((target - cur) > step) next_c = cur + step;
      end else if ((cur - target) > step) begin
        next_c = cur - step;
      end
    end
  end

endmodule

// File: rtl/pwm_channel_core.sv
// PWM timing core with period-boundary config shadowing.
// Optional duty slew limiting enabled by defining PWM_RAMP_EN.
module pwm_channel_core
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic [CNT_W-1:0] cfg_step,
  input  logic             cfg_enable,
  input  logic             cfg_invert,
  output logic             pwm_out,
  output logic             period_tick,
  output logic             ramp_busy,
  output logic [1:0]       run_state
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic [CNT_W-1:0] target_sh_q, target_sh_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] duty_next_c;
  logic             term_c;
  logic             zero_period_c;

`ifdef PWM_RAMP_EN
  pwm_slew_step #(.CNT_W(CNT_W)) u_slew (
    .cur    (duty_act_q),
    .target (cfg_duty),
    .step   (cfg_step),
    .next_c (duty_next_c)
  );
`else
  logic step_unused_c;
  assign step_unused_c = ^cfg_step;
  assign duty_next_c   = cfg_duty;
`endif

  assign zero_period_c = (period_sh_q == '0);
  assign term_c        = !zero_period_c && (cnt_q == (period_sh_q - CNT_W'(1)));

  // Next-state, counter, shadow and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_act_d  = duty_act_q;
    target_sh_d = target_sh_q;
    tick_d      = 1'b0;
    pwm_d       = IDLE_LEVEL ^ cfg_invert;

    case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          state_d     = RUN;
          cnt_d       = '0;
          period_sh_d = cfg_period;
          target_sh_d = cfg_duty;
          duty_act_d  = cfg_duty;
        end
      end
      RUN, DRAIN: begin
        pwm_d = cfg_invert ^ (cnt_q < duty_act_q);
        if (zero_period_c) begin
          // No usable period yet: hold inactive and keep sampling config.
          pwm_d       = cfg_invert;
          cnt_d       = '0;
          period_sh_d = cfg_period;
          target_sh_d = cfg_duty;
          duty_act_d  = cfg_duty;
        end else if (term_c) begin
          cnt_d       = '0;
          tick_d      = 1'b1;
          period_sh_d = cfg_period;
          target_sh_d = cfg_duty;
          duty_act_d  = duty_next_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end

        if (state_q == RUN) begin
          if (!cfg_enable) state_d = DRAIN;
        end else if (cfg_enable) begin
          state_d = RUN;
        end else if (term_c || zero_period_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PWM_RAMP_EN
    busy_d = (duty_act_d != target_sh_d);
`else
    busy_d = 1'b0;
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_sh_q <= '0;
      duty_act_q  <= '0;
      target_sh_q <= '0;
      pwm_q       <= IDLE_LEVEL ^ cfg_invert;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_act_q  <= duty_act_d;
      target_sh_q <= target_sh_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign ramp_busy   = busy_q;
  assign run_state   = state_q;

endmodule
